// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// State encoding, sequential increment and default reset/exception vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned PC_INC = 4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace-top, overwrites the oldest
// entry when full; depth count saturates at DEPTH.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end
  end

  // NOTE: entry storage has no reset; it is only read while count is non-zero,
  // so resetting it would only add reset fan-out to a plain register array.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end else if (replace && !empty) begin
      mem[top_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT fetch control with redirect priority.
// Define PC_RAS_EN to build in the return-address stack (pc_ras).
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = PC_WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                fetch_ready,
  input  logic                halt,
  input  logic                resume,
  input  logic                exc,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                call,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] ret_target,
  output logic [PC_WIDTH-1:0] PC,
  output logic                pc_valid,
  output logic                ras_underflow,
  output logic [1:0]          state_o
);

  pc_state_e           state_q;
  pc_state_e           state_d;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] ret_addr;
  logic                advance;
  logic                underflow_d;

  assign pc_valid = (state_q == RUN);
  assign state_o  = state_q;
  assign advance  = pc_valid && fetch_ready;
  assign pc_plus4 = PC + PC_WIDTH'(PC_INC);

`ifdef PC_RAS_EN
  logic                stack_op;
  logic                ras_push;
  logic                ras_pop;
  logic                ras_replace;
  logic                ras_empty;
  logic                unused_ras_full;
  logic [PC_WIDTH-1:0] ras_top;

  // exc wins over ret/call, so the stack is untouched in an exception cycle.
  assign stack_op    = advance && !exc;
  assign ras_pop     = stack_op && ret && !call;
  assign ras_replace = stack_op && ret && call;
  assign ras_push    = stack_op && !ret && call && jump;
  assign ret_addr    = ras_empty ? ret_target : ras_top;
  assign underflow_d = stack_op && ret && ras_empty;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .CLK     (CLK),
    .RST     (RST),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .wdata   (pc_plus4),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (unused_ras_full)
  );
`else
  logic unused_call;

  assign unused_call = call;
  assign ret_addr    = ret_target;
  assign underflow_d = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = PC;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (resume && !halt) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (advance) begin
      if (ret)               pc_d = ret_addr;
      else if (jump)         pc_d = jump_target;
      else if (branch_taken) pc_d = branch_target;
      else                   pc_d = pc_plus4;
    end

    if (exc) begin
      pc_d    = EXC_VECTOR;
      state_d = RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= BOOT;
      PC            <= RESET_VECTOR;
      ras_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      PC            <= pc_d;
      ras_underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expectations adapt to PC_RAS_EN.
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_ready, halt, resume, exc;
  logic        branch_taken, jump, call, ret;
  logic [31:0] branch_target, jump_target, ret_target;
  logic [31:0] PC;
  logic        pc_valid, ras_underflow;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  pc_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .fetch_ready   (fetch_ready),
    .halt          (halt),
    .resume        (resume),
    .exc           (exc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .ret_target    (ret_target),
    .PC            (PC),
    .pc_valid      (pc_valid),
    .ras_underflow (ras_underflow),
    .state_o       (state_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_redirects();
    exc = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic check_run(input string tag, input logic [31:0] exp_pc);
    check({tag, ".pc"}, PC, exp_pc);
    check({tag, ".state"}, 32'(state_o), 32'd1);
    check({tag, ".valid"}, 32'(pc_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 0; fetch_ready = 1; halt = 0; resume = 0;
    clear_redirects();
    branch_target = 0; jump_target = 0; ret_target = 0;

    // Reset state, then BOOT for one cycle after release.
    #2;
    check("rst.pc", PC, 32'h0);
    check("rst.state", 32'(state_o), 32'd0);
    check("rst.valid", 32'(pc_valid), 32'd0);
    check("rst.underflow", 32'(ras_underflow), 32'd0);
    tick();
    RST = 1;
    check("boot.state", 32'(state_o), 32'd0);
    check("boot.valid", 32'(pc_valid), 32'd0);
    check("boot.pc", PC, 32'h0);
    tick(); check_run("run0", 32'h0);
    tick(); check_run("run1", 32'h4);
    tick(); check_run("run2", 32'h8);
    tick(); tick(); check("seq.pc10", PC, 32'h10);

    // Stall: PC holds while fetch_ready is low.
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall.pc", PC, 32'h10);
    end
    fetch_ready = 1;
    tick(); check("stall.release", PC, 32'h14);

    // Priority: exc > jump > branch.
    exc = 1; jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
    tick(); check("prio.exc", PC, 32'h80);
    exc = 0;
    tick(); check("prio.jump", PC, 32'h200);
    jump = 0;
    tick(); check("prio.branch", PC, 32'h300);
    branch_taken = 0;
    jump = 1; jump_target = 32'h40;
    tick(); check("jump.to40", PC, 32'h40);

    // Call then two rets: stack hit, then underflow to ret_target.
    call = 1; jump_target = 32'h100;
    tick(); check("call.target", PC, 32'h100);
    clear_redirects();
    tick(); tick(); check("call.seq", PC, 32'h108);
    ret = 1; ret_target = 32'h600;
    tick();
    check("ret1.pc", PC, RAS ? 32'h44 : 32'h600);
    check("ret1.underflow", 32'(ras_underflow), 32'd0);
    ret_target = 32'h500;
    tick();
    check("ret2.pc", PC, 32'h500);
    check("ret2.underflow", 32'(ras_underflow), 32'(RAS));
    ret = 0;
    tick();
    check("ret2.seq", PC, 32'h504);
    check("ret2.pulse_end", 32'(ras_underflow), 32'd0);

    // Five calls into a four-deep stack, then five rets.
    call = 1; jump = 1;
    for (int k = 1; k <= 5; k++) begin
      jump_target = 32'(k) << 12;
      tick(); check("call5.pc", PC, 32'(k) << 12);
    end
    clear_redirects();
    ret = 1; ret_target = 32'h700;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ret5.pc", PC, (RAS && i < 4) ? ((32'(4 - i) << 12) + 32'h4) : 32'h700);
      check("ret5.underflow", 32'(ras_underflow), 32'(RAS && i == 4));
    end
    clear_redirects();

    // call+ret together: take the ret and replace the top with PC+4.
    call = 1; jump = 1; jump_target = 32'h800;
    tick(); check("cr.call", PC, 32'h800);
    jump = 0; ret = 1; ret_target = 32'h900;
    tick(); check("cr.both", PC, RAS ? 32'h704 : 32'h900);
    call = 0;
    tick(); check("cr.replaced", PC, RAS ? 32'h804 : 32'h900);
    check("cr.underflow", 32'(ras_underflow), 32'd0);
    tick(); check("cr.empty", PC, 32'h900);
    check("cr.empty_uf", 32'(ras_underflow), 32'(RAS));
    clear_redirects();

    // Adder wrap.
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick(); check("wrap.top", PC, 32'hFFFF_FFFC);
    jump = 0;
    tick(); check("wrap.zero", PC, 32'h0);

    // Halt after the current advance, hold through HALT, ignore redirects.
    halt = 1;
    tick();
    check("halt.pc", PC, 32'h4);
    check("halt.state", 32'(state_o), 32'd2);
    check("halt.valid", 32'(pc_valid), 32'd0);
    halt = 0; jump = 1; jump_target = 32'h300;
    tick(); check("halt.hold", PC, 32'h4);
    jump = 0; halt = 1; resume = 1;
    tick();
    check("halt.both_state", 32'(state_o), 32'd2);
    check("halt.both_pc", PC, 32'h4);
    halt = 0;
    tick(); check_run("resume", 32'h4);
    resume = 0;
    tick(); check("resume.adv", PC, 32'h8);

    // exc out of HALT.
    halt = 1;
    tick(); check("halt2.state", 32'(state_o), 32'd2);
    halt = 0; exc = 1;
    tick(); check_run("halt2.exc", 32'h80);
    exc = 0; halt = 1;
    tick(); check("halt3.pc", PC, 32'h84);
    halt = 0;

    // Asynchronous reset mid-HALT discards a pending redirect.
    #2;
    exc = 1; jump = 1; jump_target = 32'h300;
    RST = 0;
    #1;
    check("arst.pc", PC, 32'h0);
    check("arst.state", 32'(state_o), 32'd0);
    check("arst.valid", 32'(pc_valid), 32'd0);
    clear_redirects();
    tick();
    RST = 1;
    check("arst.boot_pc", PC, 32'h0);
    tick(); check_run("arst.run", 32'h0);
    tick(); check("arst.seq", PC, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
